// File: rtl/cam_rw_pkg.sv
// cam_rw_pkg: shared defaults and width helpers for the writable CAM and its front end.
//   CAM_DATA_W / CAM_LEN_W / CAM_DEPTH : default key data width, key length width, entry count
//   cam_addr_w(depth) : entry index width (at least 1)
//   cam_cnt_w(depth)  : width able to hold 0..depth
package cam_rw_pkg;

  localparam int unsigned CAM_DATA_W = 64;
  localparam int unsigned CAM_LEN_W  = 4;
  localparam int unsigned CAM_DEPTH  = 8;

  function automatic int unsigned cam_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cam_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cam_rw_if.sv
// cam_rw_if: write/clear/flush/search request bus and registered search response of cam_rw.
//   master : drives wr_*, clr_*, flush, srch_*; observes rsp_*, count, full
//   slave  : the CAM side of the same signals
interface cam_rw_if
  import cam_rw_pkg::*;
#(
  parameter int unsigned DATA_W = CAM_DATA_W,
  parameter int unsigned LEN_W  = CAM_LEN_W,
  parameter int unsigned DEPTH  = CAM_DEPTH
);
  localparam int unsigned ADDR_W = cam_addr_w(DEPTH);
  localparam int unsigned CNT_W  = cam_cnt_w(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic [DATA_W-1:0] wr_data;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              flush;
  logic              srch_req;
  logic              srch_learn;
  logic [LEN_W-1:0]  srch_len;
  logic [DATA_W-1:0] srch_data;

  logic              rsp_valid;
  logic              rsp_hit;
  logic              rsp_multi;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_learned;
  logic [CNT_W-1:0]  count;
  logic              full;

  modport master (
    output wr_en, wr_addr, wr_len, wr_data, clr_en, clr_addr, flush,
           srch_req, srch_learn, srch_len, srch_data,
    input  rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_learned, count, full
  );

  modport slave (
    input  wr_en, wr_addr, wr_len, wr_data, clr_en, clr_addr, flush,
           srch_req, srch_learn, srch_len, srch_data,
    output rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_learned, count, full
  );

endinterface

// File: rtl/cam_rw_prio_enc.sv
// cam_prio_enc: lowest-set-bit priority encoder.
//   in  : request vector
//   out : index of the lowest set bit (0 when none)
//   any : at least one bit of in is set
module cam_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]                         in,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out,
  output logic                                 any
);
  localparam int unsigned OUT_W = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    out = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in[i] && !any) begin
        out = OUT_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_rw.sv
// cam_rw: writable content-addressable memory of DEPTH {len, data} entries.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : cam_rw_if slave -- explicit write/clear/flush, one search per cycle,
//              registered response (hit, multi-hit, lowest index or learned index),
//              optional learn-on-miss with free-slot-first then round-robin victim,
//              plus registered valid-entry count and full flag.
module cam_rw
  import cam_rw_pkg::*;
#(
  parameter int unsigned DATA_W = CAM_DATA_W,
  parameter int unsigned LEN_W  = CAM_LEN_W,
  parameter int unsigned DEPTH  = CAM_DEPTH
) (
  input logic     clk,
  input logic     rst,
  cam_rw_if.slave bus
);
  localparam int unsigned ADDR_W = cam_addr_w(DEPTH);
  localparam int unsigned CNT_W  = cam_cnt_w(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [LEN_W-1:0]  r_len  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_victim;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic              r_rsp_multi;
  logic              r_rsp_learned;
  logic [ADDR_W-1:0] r_rsp_addr;

  logic [DEPTH-1:0]  w_match;
  logic [DEPTH-1:0]  w_invalid;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [ADDR_W-1:0] w_hit_idx;
  logic [ADDR_W-1:0] w_free_idx;
  logic [ADDR_W-1:0] w_ins_idx;
  logic              w_hit_any;
  logic              w_free_any;
  logic              w_multi;
  logic              w_learn;
  logic [CNT_W-1:0]  w_count_nxt;

  // Match against pre-edge contents only; same-cycle updates land after the compare.
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_len[i] == bus.srch_len) && (r_data[i] == bus.srch_data);
    end
  end

  assign w_invalid = ~r_valid;

  cam_prio_enc #(.N(DEPTH)) u_match_enc (
    .in  (w_match),
    .out (w_hit_idx),
    .any (w_hit_any)
  );

  cam_prio_enc #(.N(DEPTH)) u_free_enc (
    .in  (w_invalid),
    .out (w_free_idx),
    .any (w_free_any)
  );

  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign w_multi   = |(w_match & (w_match - DEPTH'(1)));
  assign w_learn   = bus.srch_req & bus.srch_learn & ~w_hit_any & ~bus.flush & ~bus.wr_en;
  assign w_ins_idx = w_free_any ? w_free_idx : r_victim;

  // Apply updates lowest priority first so higher-priority ones overwrite.
  always_comb begin
    w_valid_nxt = r_valid;
    if (bus.flush) begin
      w_valid_nxt = '0;
    end else begin
      if (w_learn)    w_valid_nxt[w_ins_idx]    = 1'b1;
      if (bus.clr_en) w_valid_nxt[bus.clr_addr] = 1'b0;
      if (bus.wr_en)  w_valid_nxt[bus.wr_addr]  = 1'b1;
    end
  end

  always_comb begin
    w_count_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + CNT_W'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= '0;
      r_victim      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_multi   <= 1'b0;
      r_rsp_learned <= 1'b0;
      r_rsp_addr    <= '0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_rsp_valid <= bus.srch_req;
      if (w_learn && !w_free_any) begin
        r_victim <= (r_victim == ADDR_W'(DEPTH - 1)) ? '0 : r_victim + ADDR_W'(1);
      end
      if (bus.srch_req) begin
        r_rsp_hit     <= w_hit_any;
        r_rsp_multi   <= w_multi;
        r_rsp_learned <= w_learn;
        r_rsp_addr    <= w_hit_any ? w_hit_idx : (w_learn ? w_ins_idx : '0);
      end
    end
  end

  // Key storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      if (bus.wr_en) begin
        r_len[bus.wr_addr]  <= bus.wr_len;
        r_data[bus.wr_addr] <= bus.wr_data;
      end else if (w_learn) begin
        r_len[w_ins_idx]  <= bus.srch_len;
        r_data[w_ins_idx] <= bus.srch_data;
      end
    end
  end

  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_hit     = r_rsp_hit;
  assign bus.rsp_multi   = r_rsp_multi;
  assign bus.rsp_addr    = r_rsp_addr;
  assign bus.rsp_learned = r_rsp_learned;
  assign bus.count       = r_count;
  assign bus.full        = r_full;

endmodule

// File: tb/tb_cam_rw.sv
// tb_cam_rw: directed self-checking bench for cam_rw (DEPTH=8) with a response scoreboard.
module tb_cam_rw;

  localparam int unsigned DW = 64;
  localparam int unsigned LW = 4;
  localparam int unsigned DP = 8;

  typedef struct packed {
    logic       hit;
    logic       multi;
    logic [2:0] addr;
    logic       learned;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  cam_rw_if #(.DATA_W(DW), .LEN_W(LW), .DEPTH(DP)) bus ();

  cam_rw #(.DATA_W(DW), .LEN_W(LW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en      = 1'b0;
    bus.clr_en     = 1'b0;
    bus.flush      = 1'b0;
    bus.srch_req   = 1'b0;
    bus.srch_learn = 1'b0;
  endtask

  // Advance one clock, check the response strobe and pop the scoreboard on a response.
  task automatic cyc();
    logic p;
    exp_t e;
    p = bus.srch_req && !rst;
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(p));
    if (bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'(sbq.size()), 64'd1);
      end else begin
        e = sbq.pop_front();
        chk("rsp_hit",     64'(bus.rsp_hit),     64'(e.hit));
        chk("rsp_multi",   64'(bus.rsp_multi),   64'(e.multi));
        chk("rsp_addr",    64'(bus.rsp_addr),    64'(e.addr));
        chk("rsp_learned", 64'(bus.rsp_learned), 64'(e.learned));
      end
    end
    idle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] len, input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_len  = len;
    bus.wr_data = d;
  endtask

  task automatic clr(input logic [2:0] a);
    bus.clr_en   = 1'b1;
    bus.clr_addr = a;
  endtask

  task automatic srch(input logic [3:0] len, input logic [63:0] d, input logic lrn,
                      input logic h, input logic m, input logic [2:0] a, input logic l);
    bus.srch_req   = 1'b1;
    bus.srch_learn = lrn;
    bus.srch_len   = len;
    bus.srch_data  = d;
    sbq.push_back(exp_t'{hit: h, multi: m, addr: a, learned: l});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.wr_addr = '0; bus.wr_len = '0; bus.wr_data = '0;
    bus.clr_addr = '0; bus.srch_len = '0; bus.srch_data = '0;

    // Reset values
    cyc(); cyc();
    chk("rst_hit",     64'(bus.rsp_hit), 64'd0);
    chk("rst_multi",   64'(bus.rsp_multi), 64'd0);
    chk("rst_addr",    64'(bus.rsp_addr), 64'd0);
    chk("rst_learned", 64'(bus.rsp_learned), 64'd0);
    chk("rst_count",   64'(bus.count), 64'd0);
    chk("rst_full",    64'(bus.full), 64'd0);
    rst = 1'b0;

    // Basic write then hit, and hold behaviour
    wr(3'd0, 4'd3, 64'h4F454C); cyc();
    srch(4'd3, 64'h4F454C, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0); cyc();
    chk("count_1", 64'(bus.count), 64'd1);
    cyc();
    chk("hold_hit", 64'(bus.rsp_hit), 64'd1);

    // Duplicates, multi-hit, clear
    wr(3'd2, 4'd5, 64'h1234_5678); cyc();
    wr(3'd5, 4'd5, 64'h1234_5678); cyc();
    chk("count_3", 64'(bus.count), 64'd3);
    srch(4'd5, 64'h1234_5678, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0); cyc();
    clr(3'd2); cyc();
    chk("count_clr", 64'(bus.count), 64'd2);
    srch(4'd5, 64'h1234_5678, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0); cyc();
    clr(3'd2); cyc();
    chk("count_clr_noop", 64'(bus.count), 64'd2);
    wr(3'd5, 4'd5, 64'h1234_5678); cyc();
    chk("count_overwrite", 64'(bus.count), 64'd2);

    // Same-cycle write and search sees old contents
    wr(3'd1, 4'd7, 64'hDEAD_BEEF);
    srch(4'd7, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    srch(4'd7, 64'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0); cyc();
    chk("count_wsame", 64'(bus.count), 64'd3);

    // Learn into empty CAM, then round-robin eviction with wrap
    bus.flush = 1'b1; cyc();
    chk("count_flush", 64'(bus.count), 64'd0);
    for (int i = 0; i < 8; i++) begin
      srch(4'd1, 64'hA000 + 64'(i), 1'b1, 1'b0, 1'b0, 3'(i), 1'b1); cyc();
    end
    chk("count_full", 64'(bus.count), 64'd8);
    chk("full_set",   64'(bus.full), 64'd1);
    srch(4'd1, 64'hA008, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1); cyc();
    srch(4'd1, 64'hA009, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1); cyc();
    chk("count_evict", 64'(bus.count), 64'd8);
    srch(4'd1, 64'hA008, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0); cyc();
    srch(4'd1, 64'hA000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    srch(4'd2, 64'hA005, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    srch(4'd1, 64'hA005, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0); cyc();
    for (int i = 2; i < 8; i++) begin
      srch(4'd1, 64'hA008 + 64'(i), 1'b1, 1'b0, 1'b0, 3'(i), 1'b1); cyc();
    end
    srch(4'd1, 64'hA010, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1); cyc();
    chk("full_hold", 64'(bus.full), 64'd1);

    // Write + clear same address + learning miss: write wins, learn suppressed
    bus.flush = 1'b1; cyc();
    wr(3'd3, 4'd4, 64'h55); clr(3'd3);
    srch(4'd4, 64'h66, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    chk("count_wrclr", 64'(bus.count), 64'd1);
    srch(4'd4, 64'h55, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0); cyc();
    srch(4'd4, 64'h66, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    wr(3'd4, 4'd4, 64'h77); clr(3'd3); cyc();
    chk("count_wrclr_diff", 64'(bus.count), 64'd1);
    srch(4'd4, 64'h77, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0); cyc();
    srch(4'd4, 64'h55, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    bus.flush = 1'b1;
    srch(4'd4, 64'h99, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    chk("count_flush_learn", 64'(bus.count), 64'd0);

    // Reset mid-operation with a search in the same cycle
    for (int i = 0; i < 4; i++) begin
      wr(3'(i), 4'd2, 64'hB000 + 64'(i)); cyc();
    end
    chk("count_4", 64'(bus.count), 64'd4);
    bus.srch_req = 1'b1; bus.srch_len = 4'd2; bus.srch_data = 64'hB000;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("count_rst", 64'(bus.count), 64'd0);
    chk("full_rst",  64'(bus.full), 64'd0);
    for (int i = 0; i < 4; i++) begin
      srch(4'd2, 64'hB000 + 64'(i), 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); cyc();
    end

    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
